bus_responder: RTL and testbench

- Target-side responder for the shared test bus: accepts read/write requests from the bus initiator, holds them for a configurable number of wait states, then acknowledges them.
- Backed by a small internal register file of DEPTH words.
- Flags out-of-range accesses with an error response.
- Counts completed transactions, giving the coverage benches a live end to drive against instead of a passive interface.

---
 rtl/bus_responder.sv | 146 ++++++++++++++
 tb/tb_bus_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Bus target: accepts a request, holds it WAIT_CYCLES wait states, then acks from a DEPTH-word register file.
// Optional write/read parity checking is enabled by defining BUS_RESPONDER_PARITY_EN.
module bus_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wpar,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              rpar,
   output logic              busy,
   output logic [CNT_W-1:0]  txn_cnt
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WC_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [WC_W-1:0]  WC_LOAD   = WC_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t              state_reg;
   logic [WC_W-1:0]     wait_cnt_reg;
   logic                txn_we_reg;
   logic [ADDR_W-1:0]   txn_addr_reg;
   logic [DATA_W-1:0]   txn_wdata_reg;
   logic                txn_wpar_reg;
   logic                ack_reg, err_reg, busy_reg, rpar_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [CNT_W-1:0]    txn_cnt_reg;
   logic [DATA_W-1:0]   mem [DEPTH];

   // With zero wait states the ack decision is made on the accepting edge, so
   // the transaction fields come straight from the bus rather than the latches.
   logic                src_we, src_wpar;
   logic [ADDR_W-1:0]   src_addr;
   logic [DATA_W-1:0]   src_wdata;
   logic                range_bad, par_bad, txn_bad, go_ack;
   logic [DATA_W-1:0]   rd_val;

   always_comb begin
      src_we    = (state_reg == IDLE) ? we    : txn_we_reg;
      src_addr  = (state_reg == IDLE) ? addr  : txn_addr_reg;
      src_wdata = (state_reg == IDLE) ? wdata : txn_wdata_reg;
      src_wpar  = (state_reg == IDLE) ? wpar  : txn_wpar_reg;
      range_bad = ({1'b0, src_addr} >= DEPTH_X);
`ifdef BUS_RESPONDER_PARITY_EN
      par_bad   = src_we && (src_wpar != ^src_wdata);
`else
      par_bad   = 1'b0;
`endif
      txn_bad   = range_bad || par_bad;
      rd_val    = txn_bad ? '0 : mem[src_addr[IDX_W-1:0]];
      go_ack    = req && (((state_reg == IDLE) && (WAIT_CYCLES == 0)) ||
                          ((state_reg == WAIT) && (wait_cnt_reg == '0)));
   end

`ifndef BUS_RESPONDER_PARITY_EN
   logic unused_wpar;
   assign unused_wpar = src_wpar;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         txn_we_reg    <= 1'b0;
         txn_addr_reg  <= '0;
         txn_wdata_reg <= '0;
         txn_wpar_reg  <= 1'b0;
         ack_reg       <= 1'b0;
         err_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         rpar_reg      <= 1'b0;
         rdata_reg     <= '0;
         txn_cnt_reg   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  txn_we_reg    <= we;
                  txn_addr_reg  <= addr;
                  txn_wdata_reg <= wdata;
                  txn_wpar_reg  <= wpar;
                  busy_reg      <= 1'b1;
                  wait_cnt_reg  <= WC_LOAD;
                  state_reg     <= (WAIT_CYCLES == 0) ? ACK : WAIT;
               end
            end
            WAIT: begin
               if (!req) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (wait_cnt_reg == '0) begin
                  state_reg <= ACK;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 1'b1;
               end
            end
            ACK: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               // Commit only once the ack has been seen, so an aborted or reset transaction never writes.
               if (txn_we_reg && !err_reg)
                  mem[txn_addr_reg[IDX_W-1:0]] <= txn_wdata_reg;
            end
            default: state_reg <= IDLE;
         endcase

         if (go_ack) begin
            ack_reg <= 1'b1;
            err_reg <= txn_bad;
            if (txn_cnt_reg != '1) txn_cnt_reg <= txn_cnt_reg + 1'b1;
            if (!src_we) begin
               rdata_reg <= rd_val;
`ifdef BUS_RESPONDER_PARITY_EN
               rpar_reg  <= ^rd_val;
`else
               rpar_reg  <= 1'b0;
`endif
            end
         end
      end
   end

   assign ack     = ack_reg;
   assign err     = err_reg;
   assign rdata   = rdata_reg;
   assign rpar    = rpar_reg;
   assign busy    = busy_reg;
   assign txn_cnt = txn_cnt_reg;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one default instance (2 wait states) and one with no wait states and a 2-bit counter.
module tb_bus_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        req = 1'b0, we = 1'b0, wpar = 1'b0;
   logic [7:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        ack, err, rpar, busy;
   logic [31:0] rdata;
   logic [15:0] txn_cnt;

   logic        req0 = 1'b0, we0 = 1'b0, wpar0 = 1'b0;
   logic [7:0]  addr0 = '0;
   logic [31:0] wdata0 = '0;
   logic        ack0, err0, rpar0, busy0;
   logic [31:0] rdata0;
   logic [1:0]  txn_cnt0;

   int n_checks = 0;
   int n_fail   = 0;

   bus_responder dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wpar(wpar),
      .ack(ack), .err(err), .rdata(rdata), .rpar(rpar), .busy(busy), .txn_cnt(txn_cnt)
   );

   bus_responder #(.WAIT_CYCLES(0), .CNT_W(2)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .wpar(wpar0),
      .ack(ack0), .err(err0), .rdata(rdata0), .rpar(rpar0), .busy(busy0), .txn_cnt(txn_cnt0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one complete transaction on the default instance and returns what the ack cycle showed.
   task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d, input logic p,
                         output logic e, output logic [31:0] rd, output logic rp, output int lat);
      we = w; addr = a; wdata = d; wpar = p; req = 1'b1;
      lat = 0; e = 1'b0; rd = '0; rp = 1'b0;
      do begin
         tick();
         lat++;
      end while (!ack && lat < 20);
      n_checks++;
      if (!ack) begin
         n_fail++;
         $display("FAIL txn_timeout: addr=%0d got no ack, required ack within 20 cycles", a);
      end else begin
         e = err; rd = rdata; rp = rpar;
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_ack: got %b, required 1", busy);
         end
      end
      req = 1'b0;
      tick();
      $display("txn we=%0d addr=%0d wdata=%08h wpar=%0d -> lat=%0d err=%0d rdata=%08h rpar=%0d txn_cnt=%0d",
               w, a, d, p, lat, e, rd, rp, txn_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if ({ack, err, busy, rpar} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got ack/err/busy/rpar=%b, required 0000", {ack, err, busy, rpar});
      end
      n_checks++;
      if (rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %08h, required 00000000", rdata);
      end
      n_checks++;
      if (txn_cnt !== 16'd0 || txn_cnt0 !== 2'd0 || ack0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cnt: got txn_cnt=%0d txn_cnt0=%0d ack0=%b, required 0 0 0", txn_cnt, txn_cnt0, ack0);
      end
   endtask

   task automatic test_write_read();
      logic e, rp;
      logic [31:0] rd;
      int lat;
      do_txn(1'b1, 8'd3, 32'hDEADBEEF, ^32'hDEADBEEF, e, rd, rp, lat);
      n_checks++;
      if (lat !== 3 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_ack: got lat=%0d err=%b, required lat=3 err=0", lat, e);
      end
      do_txn(1'b0, 8'd3, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_after_wr: got lat=%0d err=%b rdata=%08h, required 3 0 deadbeef", lat, e, rd);
      end
      n_checks++;
      if (txn_cnt !== 16'd2 || rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL cnt_hold: got txn_cnt=%0d rdata=%08h, required 2 deadbeef", txn_cnt, rdata);
      end
   endtask

   task automatic test_out_of_range();
      logic e, rp;
      logic [31:0] rd;
      int lat;
      do_txn(1'b0, 8'd16, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (lat !== 3 || e !== 1'b1 || rd !== 32'h0 || txn_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL oor_read: got lat=%0d err=%b rdata=%08h cnt=%0d, required 3 1 00000000 3", lat, e, rd, txn_cnt);
      end
      do_txn(1'b1, 8'd16, 32'hAAAA5555, ^32'hAAAA5555, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b1 || txn_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL oor_write: got err=%b cnt=%0d, required 1 4", e, txn_cnt);
      end
      do_txn(1'b0, 8'd0, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0 || rd !== 32'h0 || txn_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL read_addr0: got err=%b rdata=%08h cnt=%0d, required 0 00000000 5", e, rd, txn_cnt);
      end
      do_txn(1'b0, 8'd15, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0 || rd !== 32'h0 || txn_cnt !== 16'd6) begin
         n_fail++;
         $display("FAIL read_addr15: got err=%b rdata=%08h cnt=%0d, required 0 00000000 6", e, rd, txn_cnt);
      end
   endtask

   task automatic test_abort();
      logic e, rp;
      logic [31:0] rd;
      int lat;
      we = 1'b1; addr = 8'd5; wdata = 32'h12345678; wpar = ^32'h12345678; req = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b1 || ack !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_accept: got busy=%b ack=%b, required 1 0", busy, ack);
      end
      tick();
      req = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || ack !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_drop: got busy=%b ack=%b, required 0 0", busy, ack);
      end
      tick();
      n_checks++;
      if (ack !== 1'b0 || txn_cnt !== 16'd6) begin
         n_fail++;
         $display("FAIL abort_cnt: got ack=%b cnt=%0d, required 0 6", ack, txn_cnt);
      end
      $display("txn we=1 addr=5 wdata=12345678 aborted in wait txn_cnt=%0d", txn_cnt);
      do_txn(1'b0, 8'd5, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0 || rd !== 32'h0 || txn_cnt !== 16'd7) begin
         n_fail++;
         $display("FAIL abort_nowrite: got err=%b rdata=%08h cnt=%0d, required 0 00000000 7", e, rd, txn_cnt);
      end
   endtask

   task automatic test_reset_midflight();
      logic e, rp;
      logic [31:0] rd;
      int lat;
      we = 1'b1; addr = 8'd7; wdata = 32'h55AA55AA; wpar = ^32'h55AA55AA; req = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({ack, err, busy, rpar} !== 4'b0000 || rdata !== 32'h0 || txn_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_inflight: got flags=%b rdata=%08h cnt=%0d, required 0000 00000000 0",
                  {ack, err, busy, rpar}, rdata, txn_cnt);
      end
      rst = 1'b0;
      req = 1'b0;
      tick();
      $display("txn we=1 addr=7 wdata=55aa55aa killed by reset txn_cnt=%0d", txn_cnt);
      do_txn(1'b0, 8'd7, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0 || rd !== 32'h0 || txn_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL rst_nowrite: got err=%b rdata=%08h cnt=%0d, required 0 00000000 1", e, rd, txn_cnt);
      end
      do_txn(1'b0, 8'd3, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (rd !== 32'h0 || txn_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL rst_memclear: got rdata=%08h cnt=%0d, required 00000000 2", rd, txn_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic       exp_ack;
      logic [1:0] exp_cnt;
      n_checks++;
      if (txn_cnt0 !== 2'd0) begin
         n_fail++;
         $display("FAIL b2b_start: got txn_cnt0=%0d, required 0", txn_cnt0);
      end
      we0 = 1'b0; addr0 = 8'd2; req0 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_ack = (i % 2 == 1);
         n_checks++;
         if (ack0 !== exp_ack || (ack0 && err0 !== 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_ack cycle %0d: got ack0=%b err0=%b, required ack0=%b err0=0", i, ack0, err0, exp_ack);
         end
         if (i % 2 == 0) begin
            exp_cnt = (i / 2 >= 3) ? 2'd3 : 2'(i / 2);
            n_checks++;
            if (txn_cnt0 !== exp_cnt) begin
               n_fail++;
               $display("FAIL b2b_cnt cycle %0d: got %0d, required %0d", i, txn_cnt0, exp_cnt);
            end
            $display("txn b2b read addr=2 cycle=%0d txn_cnt0=%0d", i, txn_cnt0);
         end
      end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_parity();
      logic e, rp;
      logic [31:0] rd;
      int lat;
`ifdef BUS_RESPONDER_PARITY_EN
      do_txn(1'b1, 8'd9, 32'h00000001, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b1) begin
         n_fail++;
         $display("FAIL par_bad_write: got err=%b, required 1", e);
      end
      do_txn(1'b0, 8'd9, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0 || rd !== 32'h0 || rp !== 1'b0) begin
         n_fail++;
         $display("FAIL par_nowrite: got err=%b rdata=%08h rpar=%b, required 0 00000000 0", e, rd, rp);
      end
      do_txn(1'b1, 8'd9, 32'h00000003, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0) begin
         n_fail++;
         $display("FAIL par_good_write: got err=%b, required 0", e);
      end
      do_txn(1'b0, 8'd9, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (rd !== 32'h00000003 || rp !== 1'b0) begin
         n_fail++;
         $display("FAIL par_read3: got rdata=%08h rpar=%b, required 00000003 0", rd, rp);
      end
      do_txn(1'b1, 8'd10, 32'h00000007, 1'b1, e, rd, rp, lat);
      do_txn(1'b0, 8'd10, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (rd !== 32'h00000007 || rp !== 1'b1) begin
         n_fail++;
         $display("FAIL par_read7: got rdata=%08h rpar=%b, required 00000007 1", rd, rp);
      end
`else
      do_txn(1'b1, 8'd9, 32'h00000001, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (e !== 1'b0) begin
         n_fail++;
         $display("FAIL wpar_ignored: got err=%b, required 0", e);
      end
      do_txn(1'b0, 8'd9, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (rd !== 32'h00000001 || rp !== 1'b0) begin
         n_fail++;
         $display("FAIL rpar_tied: got rdata=%08h rpar=%b, required 00000001 0", rd, rp);
      end
      do_txn(1'b1, 8'd10, 32'h00000007, 1'b1, e, rd, rp, lat);
      do_txn(1'b0, 8'd10, 32'h0, 1'b0, e, rd, rp, lat);
      n_checks++;
      if (rd !== 32'h00000007 || rp !== 1'b0) begin
         n_fail++;
         $display("FAIL read7_nopar: got rdata=%08h rpar=%b, required 00000007 0", rd, rp);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_abort();
      test_reset_midflight();
      test_back_to_back();
      test_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
